// File: rtl/shift_unit_seq.sv
// shift_unit_seq
// Multi-cycle shift/rotate unit. An accepted request is worked off in steps of
// up to STEP positions per clock, so the shifter only needs to move 0..STEP
// places per cycle regardless of WIDTH.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request, sampled only while busy=0
//   in         operand, latched on acceptance
//   s          shift amount 0..WIDTH-1, latched on acceptance
//   mode       00 LSR, 01 LSL, 10 ASR, 11 ROR, latched on acceptance
//   out        result register (the working data register itself)
//   cout       last bit shifted or rotated out
//   busy       high whenever the FSM is not idle
//   done       one-cycle pulse when the result is ready
//   dbg_state  current FSM state encoding (0 IDLE, 1 SHIFT, 2 DONE)
//
// Handshake: a request is taken on a rising edge where start=1 and busy=0.
// Requests seen while busy=1 are dropped. The result is valid during the
// single cycle where done=1 and is held afterwards until the next acceptance.
module shift_unit_seq #(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH-1:0]           in,
  input  logic [$clog2(WIDTH)-1:0]   s,
  input  logic [1:0]                 mode,
  output logic [WIDTH-1:0]           out,
  output logic                       cout,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 dbg_state
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_K = SW'(STEP);

  localparam logic [1:0] MODE_LSR = 2'b00;
  localparam logic [1:0] MODE_LSL = 2'b01;
  localparam logic [1:0] MODE_ASR = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SW-1:0]    rem_q, rem_d;
  logic [1:0]       mode_q, mode_d;
  logic             cout_q, cout_d;

  // Per-step shifter: moves the data register by k = min(STEP, rem) places.
  logic [SW-1:0]    step_k;
  logic [SW-1:0]    step_km1;
  logic [SW:0]      step_wk;     // WIDTH - k, one bit wider so WIDTH fits
  logic [WIDTH-1:0] step_data;
  logic             step_bit;

  always_comb begin
    step_k    = (rem_q > STEP_K) ? STEP_K : rem_q;
    step_km1  = step_k - 1'b1;
    step_wk   = (SW+1)'(WIDTH) - {1'b0, step_k};
    step_data = data_q;
    step_bit  = 1'b0;
    // Index values are only meaningful when k >= 1, which is the only case
    // where the result is used.
    case (mode_q)
      MODE_LSR: begin
        step_data = data_q >> step_k;
        step_bit  = data_q[step_km1];
      end
      MODE_LSL: begin
        step_data = data_q << step_k;
        step_bit  = data_q[step_wk[SW-1:0]];
      end
      MODE_ASR: begin
        step_data = $unsigned($signed(data_q) >>> step_k);
        step_bit  = data_q[step_km1];
      end
      MODE_ROR: begin
        step_data = (data_q >> step_k) | (data_q << step_wk);
        step_bit  = data_q[step_km1];
      end
      default: begin
        step_data = data_q;
        step_bit  = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d  = in;
          rem_d   = s;
          mode_d  = mode;
          cout_d  = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (rem_q == '0) begin
          state_d = ST_DONE;
        end else begin
          data_d = step_data;
          cout_d = step_bit;
          rem_d  = rem_q - step_k;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      mode_q  <= MODE_LSR;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
      cout_q  <= cout_d;
    end
  end

  assign out       = data_q;
  assign cout      = cout_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_shift_unit_seq.sv
// Testbench for shift_unit_seq: one instance with STEP=1, one with STEP=2.
// Drivers push {expected done cycle, out, cout} into per-instance queues; a
// monitor pops and compares whenever an instance raises done.
module tb_shift_unit_seq;

  localparam int W  = 4;
  localparam int EW = 16 + W + 1;

  localparam logic [1:0] LSR = 2'b00;
  localparam logic [1:0] LSL = 2'b01;
  localparam logic [1:0] ASR = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic         start1 = 1'b0, start2 = 1'b0;
  logic [W-1:0] in1 = '0, in2 = '0;
  logic [1:0]   s1 = '0, s2 = '0;
  logic [1:0]   mode1 = '0, mode2 = '0;
  logic [W-1:0] out1, out2;
  logic         cout1, cout2, busy1, busy2, done1, done2;
  logic [1:0]   st1, st2;

  shift_unit_seq #(.WIDTH(W), .STEP(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .in(in1), .s(s1), .mode(mode1),
    .out(out1), .cout(cout1), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  shift_unit_seq #(.WIDTH(W), .STEP(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .in(in2), .s(s2), .mode(mode2),
    .out(out2), .cout(cout2), .busy(busy2), .done(done2), .dbg_state(st2)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q1[$];
  logic [EW-1:0] exp_q2[$];
  int n_tests = 0;
  int n_fail  = 0;
  int pushed1 = 0, pushed2 = 0;
  int dones1  = 0, dones2  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_done(input string tag, input logic [EW-1:0] e,
                              input logic [W-1:0] o, input logic c);
    check({tag, "_out"},  32'(o), 32'(e[W:1]));
    check({tag, "_cout"}, 32'(c), 32'(e[0]));
    check({tag, "_lat"},  cyc & 32'hffff, 32'(e[EW-1:W+1]));
  endtask

  task automatic monitor_loop();
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (done1) begin
        dones1++;
        if (exp_q1.size() == 0) check("dut1_unexpected_done", 1, 0);
        else begin
          e = exp_q1.pop_front();
          compare_done("dut1", e, out1, cout1);
        end
      end
      if (done2) begin
        dones2++;
        if (exp_q2.size() == 0) check("dut2_unexpected_done", 1, 0);
        else begin
          e = exp_q2.pop_front();
          compare_done("dut2", e, out2, cout2);
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  // Waits for the selected instance to go idle, presents one request for one
  // cycle and (optionally) records the expected result and done cycle.
  task automatic run_op(input int sel, input logic [W-1:0] a, input logic [1:0] sh,
                        input logic [1:0] md, input logic [W-1:0] eo, input logic ec,
                        input bit push);
    int step, c, waited;
    logic [15:0] ecyc;
    step = (sel == 1) ? 1 : 2;
    waited = 0;
    while (((sel == 1) ? busy1 : busy2) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("idle_wait_timeout", 1, 0);
    c = (int'(sh) + step - 1) / step;
    ecyc = 16'(cyc + 32'(c) + 2);
    if (sel == 1) begin
      start1 = 1'b1; in1 = a; s1 = sh; mode1 = md;
      if (push) begin exp_q1.push_back({ecyc, eo, ec}); pushed1++; end
    end else begin
      start2 = 1'b1; in2 = a; s2 = sh; mode2 = md;
      if (push) begin exp_q2.push_back({ecyc, eo, ec}); pushed2++; end
    end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int bcnt;
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_out1",  32'(out1),  0);
    check("rst_cout1", 32'(cout1), 0);
    check("rst_busy1", 32'(busy1), 0);
    check("rst_done1", 32'(done1), 0);
    check("rst_busy2", 32'(busy2), 0);
    rst = 1'b0;
    @(negedge clk);

    // LSR 1011 >> 2, with busy width measured
    run_op(1, 4'b1011, 2'd2, LSR, 4'b0010, 1'b1, 1'b1);
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy1) bcnt++;
      @(negedge clk);
    end
    check("lsr_busy_cycles", 32'(bcnt), 4);

    // directed vectors on the STEP=1 instance
    run_op(1, 4'b1011, 2'd1, LSL, 4'b0110, 1'b1, 1'b1);
    run_op(1, 4'b1000, 2'd3, ASR, 4'b1111, 1'b0, 1'b1);
    run_op(1, 4'b1001, 2'd1, ROR, 4'b1100, 1'b1, 1'b1);
    run_op(1, 4'b1010, 2'd0, LSR, 4'b1010, 1'b0, 1'b1);
    run_op(1, 4'b0111, 2'd0, ASR, 4'b0111, 1'b0, 1'b1);
    run_op(1, 4'b1101, 2'd0, ROR, 4'b1101, 1'b0, 1'b1);
    run_op(1, 4'b0001, 2'd3, LSL, 4'b1000, 1'b0, 1'b1);
    run_op(1, 4'b0011, 2'd3, ROR, 4'b0110, 1'b0, 1'b1);
    run_op(1, 4'b0110, 2'd2, ASR, 4'b0001, 1'b1, 1'b1);

    // STEP=2 instance: multi-position steps and a trailing 1-step
    run_op(2, 4'b0110, 2'd3, ROR, 4'b1100, 1'b1, 1'b1);
    run_op(2, 4'b1111, 2'd3, LSR, 4'b0001, 1'b1, 1'b1);
    run_op(2, 4'b0101, 2'd2, LSL, 4'b0100, 1'b1, 1'b1);
    run_op(2, 4'b1001, 2'd1, ASR, 4'b1100, 1'b1, 1'b1);

    // start held with other operands while busy, including the DONE cycle
    run_op(1, 4'b1011, 2'd3, LSR, 4'b0001, 1'b0, 1'b1);
    start1 = 1'b1; in1 = 4'b0101; s1 = 2'd1; mode1 = LSL;
    repeat (5) @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    check("ignore_stays_idle", 32'(busy1), 0);

    // reset in the middle of SHIFT
    run_op(1, 4'b1011, 2'd3, LSL, 4'b0000, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out",  32'(out1),  0);
    check("midrst_cout", 32'(cout1), 0);
    check("midrst_busy", 32'(busy1), 0);
    check("midrst_done", 32'(done1), 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_done", 32'(done1), 0);
    run_op(1, 4'b1011, 2'd2, LSR, 4'b0010, 1'b1, 1'b1);

    // drain and final bookkeeping
    for (int i = 0; i < 50 && (exp_q1.size() != 0 || exp_q2.size() != 0); i++)
      @(negedge clk);
    repeat (4) @(negedge clk);
    check("q1_drained", 32'(exp_q1.size()), 0);
    check("q2_drained", 32'(exp_q2.size()), 0);
    check("dut1_done_count", 32'(dones1), 32'(pushed1));
    check("dut2_done_count", 32'(dones2), 32'(pushed2));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
